// File: rtl/decode_pkg.sv
// Shared types and constants for the decode/issue stage.
//   state_t : assembly state (RUN = normal decode, IMM = waiting for immediate word)
//   qual_t  : decode qualifiers that travel with an instruction
package decode_pkg;

    localparam int CTRL_W_DEFAULT = 24;
    localparam int INSTR_W        = 16;
    localparam int PC_W           = 32;

    typedef enum logic {
        RUN = 1'b0,
        IMM = 1'b1
    } state_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
        logic is_load;
    } qual_t;

    // True when a source operand reads the register the load in EX will write.
    function automatic logic src_conflict(input logic used, input logic addr_match);
        return used & addr_match;
    endfunction

endpackage

// File: rtl/reg_file_bypass.sv
// N_REGS x WIDTH register file, two combinational read ports, one write port.
// A read of the address being written in the same cycle returns the write data.
//   clk, reset       : clock, synchronous active-high reset (clears every entry)
//   we, waddr, wdata : write port, committed on the rising edge
//   raddr1/2, rdata1/2 : read ports
module reg_file_bypass #(
    parameter int  WIDTH  = 16,
    parameter int  N_REGS = 8,
    localparam int AW     = $clog2(N_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] regs [N_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue pipeline stage between fetch and execute.
// Reads operands from a write-through register file, interlocks on load-use,
// handles flush/hold and assembles two-word (opcode + immediate) instructions.
//   Inputs : in_valid/instruction/pc/ctrl_in + decode qualifiers and register
//            fields from fetch/control, flush, hold, writeback port wb_*.
//   Outputs: registered ID/EX slot (out_valid, ctrl_out, rs1_data, rs2_data,
//            rd_out, imm_out, pc_out) and combinational stall_out to fetch.
//
// state | meaning
// RUN   | decoding single words; a two-word opcode is latched here
// IMM   | first word latched, next valid word is its immediate
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int  WIDTH  = 16,
    parameter int  N_REGS = 8,
    parameter int  CTRL_W = CTRL_W_DEFAULT,
    localparam int AW     = $clog2(N_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [PC_W-1:0]    pc,
    input  logic [CTRL_W-1:0]  ctrl_in,
    input  logic               uses_rs1,
    input  logic               uses_rs2,
    input  logic               writes_rd,
    input  logic               is_load,
    input  logic               two_word,
    input  logic [AW-1:0]      rs1_addr,
    input  logic [AW-1:0]      rs2_addr,
    input  logic [AW-1:0]      rd_addr,
    input  logic               flush,
    input  logic               hold,
    input  logic               wb_we,
    input  logic [AW-1:0]      wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    output logic               stall_out,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  ctrl_out,
    output logic [WIDTH-1:0]   rs1_data,
    output logic [WIDTH-1:0]   rs2_data,
    output logic [AW-1:0]      rd_out,
    output logic [WIDTH-1:0]   imm_out,
    output logic [PC_W-1:0]    pc_out
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        qual_t             qual;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
        logic [AW-1:0]     rd;
        logic [PC_W-1:0]   pc;
    } latched_t;

    state_t     state;
    latched_t   first_word;
    logic       ex_is_load;

    qual_t      in_qual;
    qual_t      iss_qual;
    logic [AW-1:0] iss_rs1;
    logic [AW-1:0] iss_rs2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic       issue_run;
    logic       issue_imm;
    logic       hazard;
    logic       issue;

    assign in_qual = '{uses_rs1: uses_rs1, uses_rs2: uses_rs2,
                       writes_rd: writes_rd, is_load: is_load};

    // In IMM the instruction being issued is the latched first word, so its
    // qualifiers and source fields come from the latch, not from fetch.
    assign iss_qual = (state == IMM) ? first_word.qual : in_qual;
    assign iss_rs1  = (state == IMM) ? first_word.rs1  : rs1_addr;
    assign iss_rs2  = (state == IMM) ? first_word.rs2  : rs2_addr;

    assign issue_run = (state == RUN) && in_valid && !two_word;
    assign issue_imm = (state == IMM) && in_valid;

    // Only an instruction that actually issues this cycle can interlock; a
    // first word being latched reads its operands later, in IMM.
    assign hazard = (issue_run || issue_imm) && ex_is_load && out_valid &&
                    (src_conflict(iss_qual.uses_rs1, iss_rs1 == rd_out) ||
                     src_conflict(iss_qual.uses_rs2, iss_rs2 == rd_out));

    assign issue     = (issue_run || issue_imm) && !hazard;
    assign stall_out = !flush && (hold || hazard);

    reg_file_bypass #(
        .WIDTH  (WIDTH),
        .N_REGS (N_REGS)
    ) u_rf (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (iss_rs1),
        .raddr2 (iss_rs2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state      <= RUN;
            first_word <= '0;
            ex_is_load <= 1'b0;
            out_valid  <= 1'b0;
            ctrl_out   <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            rd_out     <= '0;
            imm_out    <= '0;
            pc_out     <= '0;
        end else if (!hold) begin
            // Bubble unless something issues below.
            ex_is_load <= 1'b0;
            out_valid  <= 1'b0;
            ctrl_out   <= '0;
            rs1_data   <= '0;
            rs2_data   <= '0;
            rd_out     <= '0;
            imm_out    <= '0;
            pc_out     <= '0;

            if (issue) begin
                out_valid <= 1'b1;
                rs1_data  <= rd1;
                rs2_data  <= rd2;
                // A load that writes no register cannot feed a younger instruction.
                ex_is_load <= iss_qual.is_load & iss_qual.writes_rd;
                if (state == IMM) begin
                    ctrl_out <= first_word.ctrl;
                    rd_out   <= first_word.rd;
                    pc_out   <= first_word.pc;
                    imm_out  <= WIDTH'(instruction);
                end else begin
                    ctrl_out <= ctrl_in;
                    rd_out   <= rd_addr;
                    pc_out   <= pc;
                end
            end

            if (!hazard) begin
                case (state)
                    RUN: begin
                        if (in_valid && two_word) begin
                            first_word <= '{ctrl: ctrl_in, qual: in_qual,
                                            rs1: rs1_addr, rs2: rs2_addr,
                                            rd: rd_addr, pc: pc};
                            state      <= IMM;
                        end
                    end
                    IMM: begin
                        if (in_valid) begin
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
module tb_decode_issue_stage;

    localparam int WIDTH  = 32;
    localparam int N_REGS = 16;
    localparam int CTRL_W = 24;
    localparam int AW     = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [15:0]       instruction;
    logic [31:0]       pc;
    logic [CTRL_W-1:0] ctrl_in;
    logic              uses_rs1, uses_rs2, writes_rd, is_load, two_word;
    logic [AW-1:0]     rs1_addr, rs2_addr, rd_addr;
    logic              flush, hold;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              stall_out;
    logic              out_valid;
    logic [CTRL_W-1:0] ctrl_out;
    logic [WIDTH-1:0]  rs1_data, rs2_data;
    logic [AW-1:0]     rd_out;
    logic [WIDTH-1:0]  imm_out;
    logic [31:0]       pc_out;

    decode_issue_stage #(.WIDTH(WIDTH), .N_REGS(N_REGS), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .instruction(instruction),
        .pc(pc), .ctrl_in(ctrl_in), .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
        .writes_rd(writes_rd), .is_load(is_load), .two_word(two_word),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .flush(flush), .hold(hold), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall_out(stall_out), .out_valid(out_valid),
        .ctrl_out(ctrl_out), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rd_out(rd_out), .imm_out(imm_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                full;
        logic              ov;
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH-1:0]  r1;
        logic [WIDTH-1:0]  r2;
        logic [AW-1:0]     rd;
        logic [WIDTH-1:0]  imm;
        logic [31:0]       pc;
        string             name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic push_full(input string n, input logic [CTRL_W-1:0] c,
                             input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                             input logic [AW-1:0] rd, input logic [WIDTH-1:0] imm,
                             input logic [31:0] p);
        exp_t e;
        e.full = 1'b1; e.ov = 1'b1; e.ctrl = c; e.r1 = r1; e.r2 = r2;
        e.rd = rd; e.imm = imm; e.pc = p; e.name = n;
        q.push_back(e);
    endtask

    task automatic push_zero(input string n);
        exp_t e;
        e.full = 1'b1; e.ov = 1'b0; e.ctrl = '0; e.r1 = '0; e.r2 = '0;
        e.rd = '0; e.imm = '0; e.pc = '0; e.name = n;
        q.push_back(e);
    endtask

    task automatic push_bubble(input string n);
        exp_t e;
        e.full = 1'b0; e.ov = 1'b0; e.ctrl = '0; e.r1 = '0; e.r2 = '0;
        e.rd = '0; e.imm = '0; e.pc = '0; e.name = n;
        q.push_back(e);
    endtask

    task automatic chk_stall(input string n, input logic exp);
        #1;
        checks++;
        if (stall_out !== exp) begin
            fails++;
            $display("FAIL stall_%s: got %b want %b", n, stall_out, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; instruction = '0; pc = '0; ctrl_in = '0;
        uses_rs1 = 0; uses_rs2 = 0; writes_rd = 0; is_load = 0; two_word = 0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
        flush = 0; hold = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic word(input logic tw, input logic ld, input logic [CTRL_W-1:0] c,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] ad, input logic [15:0] ins,
                        input logic [31:0] p);
        in_valid = 1; two_word = tw; is_load = ld; ctrl_in = c;
        uses_rs1 = 1; uses_rs2 = 1; writes_rd = 1;
        rs1_addr = a1; rs2_addr = a2; rd_addr = ad; instruction = ins; pc = p;
    endtask

    // Monitor: pops one expectation per clock once the stage has something queued.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                ok = (out_valid === e.ov) && (ctrl_out === e.ctrl);
                if (e.full)
                    ok = ok && (rs1_data === e.r1) && (rs2_data === e.r2) &&
                         (rd_out === e.rd) && (imm_out === e.imm) && (pc_out === e.pc);
                checks++;
                if (!ok) begin
                    fails++;
                    $display("FAIL %s: got v=%b ctrl=%h rs1=%h rs2=%h rd=%h imm=%h pc=%h want v=%b ctrl=%h rs1=%h rs2=%h rd=%h imm=%h pc=%h (full=%0b)",
                             e.name, out_valid, ctrl_out, rs1_data, rs2_data, rd_out, imm_out, pc_out,
                             e.ov, e.ctrl, e.r1, e.r2, e.rd, e.imm, e.pc, e.full);
                end
            end
        end
    end

    initial begin
        reset = 1;
        idle();

        // Reset, with traffic and a writeback that reset must override.
        @(negedge clk); reset = 1; push_zero("reset0");
        @(negedge clk); reset = 1; word(0, 0, 24'hFFFFFF, 4'd1, 4'd2, 4'd3, 16'h9999, 32'h9);
        wb_we = 1; wb_addr = 4'd5; wb_data = 32'h5555; push_zero("reset1");

        // Write-through: r3 written and read the same cycle; r5 must be 0.
        @(negedge clk); reset = 0; idle();
        word(0, 0, 24'h0A0A01, 4'd3, 4'd5, 4'd4, 16'h1111, 32'h100);
        wb_we = 1; wb_addr = 4'd3; wb_data = 32'h1234;
        chk_stall("bypass", 0);
        push_full("bypass", 24'h0A0A01, 32'h1234, 32'h0, 4'd4, 32'h0, 32'h100);

        // Load to r2.
        @(negedge clk); idle(); word(0, 1, 24'h000002, 4'd3, 4'd0, 4'd2, 16'h2222, 32'h104);
        chk_stall("load", 0);
        push_full("load", 24'h000002, 32'h1234, 32'h0, 4'd2, 32'h0, 32'h104);

        // Consumer of r2: one bubble while the load data is written back.
        @(negedge clk); idle(); word(0, 0, 24'h000003, 4'd3, 4'd2, 4'd5, 16'h3333, 32'h108);
        wb_we = 1; wb_addr = 4'd2; wb_data = 32'h7777;
        chk_stall("loaduse", 1);
        push_bubble("loaduse_bubble");
        @(negedge clk); idle(); word(0, 0, 24'h000003, 4'd3, 4'd2, 4'd5, 16'h3333, 32'h108);
        chk_stall("retry", 0);
        push_full("retry", 24'h000003, 32'h1234, 32'h7777, 4'd5, 32'h0, 32'h108);

        // Two-word: opcode, an idle cycle in IMM, then the immediate.
        @(negedge clk); idle(); word(1, 0, 24'h00005A, 4'd3, 4'd2, 4'd6, 16'h5A00, 32'h20);
        chk_stall("tw_first", 0);
        push_bubble("tw_first");
        @(negedge clk); idle();
        chk_stall("imm_wait", 0);
        push_bubble("imm_wait");
        @(negedge clk); idle(); word(0, 0, 24'h0000EE, 4'd9, 4'd9, 4'd9, 16'hBEEF, 32'h22);
        chk_stall("tw_imm", 0);
        push_full("tw_issue", 24'h00005A, 32'h1234, 32'h7777, 4'd6, 32'h0000BEEF, 32'h20);

        // Idle in RUN.
        @(negedge clk); idle();
        push_bubble("run_idle");

        // Flush while in IMM; flush outranks a simultaneous hold.
        @(negedge clk); idle(); word(1, 0, 24'h000077, 4'd1, 4'd1, 4'd1, 16'h7700, 32'h40);
        push_bubble("tw_flushed_first");
        @(negedge clk); idle(); word(0, 0, 24'h000088, 4'd1, 4'd1, 4'd1, 16'hCAFE, 32'h42);
        flush = 1; hold = 1;
        chk_stall("flush", 0);
        push_zero("flush");
        @(negedge clk); idle(); word(0, 0, 24'h000011, 4'd2, 4'd3, 4'd7, 16'h1234, 32'h50);
        chk_stall("after_flush", 0);
        push_full("after_flush", 24'h000011, 32'h7777, 32'h1234, 4'd7, 32'h0, 32'h50);

        // Hold for three cycles, with a writeback to r15 during the hold.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); word(0, 0, 24'h000099, 4'd1, 4'd1, 4'd1, 16'h9900, 32'h58);
            hold = 1;
            if (i == 0) begin
                wb_we = 1; wb_addr = 4'd15; wb_data = 32'hDEADBEEF;
            end
            chk_stall("hold", 1);
            push_full("hold", 24'h000011, 32'h7777, 32'h1234, 4'd7, 32'h0, 32'h50);
        end
        @(negedge clk); idle(); word(0, 0, 24'h000022, 4'd15, 4'd7, 4'd1, 16'h2200, 32'h60);
        chk_stall("release", 0);
        push_full("release_r15", 24'h000022, 32'hDEADBEEF, 32'h0, 4'd1, 32'h0, 32'h60);

        // Reset in the middle of two-word assembly.
        @(negedge clk); idle(); word(1, 0, 24'h000033, 4'd1, 4'd1, 4'd1, 16'h3300, 32'h70);
        push_bubble("tw_reset_first");
        @(negedge clk); idle(); reset = 1;
        push_zero("mid_imm_reset");
        @(negedge clk); reset = 0; idle(); word(0, 0, 24'h000044, 4'd15, 4'd3, 4'd3, 16'hABCD, 32'h80);
        chk_stall("post_reset", 0);
        push_full("post_reset", 24'h000044, 32'h0, 32'h0, 4'd3, 32'h0, 32'h80);

        @(negedge clk); idle();
        push_bubble("final_idle");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised successor to the decode stage: a decode/issue pipeline stage with a configurable-width and configurable-depth register file. It adds write-through bypass, load-use interlock, flush/hold handling and two-word (immediate) instruction assembly. It sits between fetch and execute, takes pre-decoded control from the control unit, and drives the registered ID/EX pipeline outputs plus a stall request back to fetch.

## Interface
- WIDTH, 16: data/register width; must be ≥16.
- N_REGS, 8: register count, ≥2; AW = $clog2(N_REGS) derived.
- CTRL_W, 24: width of opaque control bundle passed to execute.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, same clock domain.
- in_valid  in  1  fetch presents a word this cycle.
- instruction  in  16  fetched word (opcode word or immediate word).
- pc  in  32  PC of the presented word.
- ctrl_in  in  CTRL_W  control bundle for instruction.
- uses_rs1, uses_rs2, writes_rd, is_load, two_word  in  1 each  decode qualifiers for instruction.
- rs1_addr, rs2_addr, rd_addr  in  AW each  extracted register fields.
- flush  in  1  kill in-flight decode (taken branch/interrupt).
- hold  in  1  freeze stage (downstream stall).
- wb_we  in  1  writeback enable.
- wb_addr  in  AW  writeback register.
- wb_data  in  WIDTH  writeback data.
- stall_out  out  1  combinational; fetch must re-present the same word next cycle.
- out_valid  out  1  registered; ID/EX slot holds a real instruction.
- ctrl_out  out  CTRL_W  registered control bundle.
- rs1_data, rs2_data  out  WIDTH  registered operands.
- rd_out  out  AW  registered destination.
- imm_out  out  WIDTH  registered immediate, zero-extended; 0 for one-word instructions.
- pc_out  out  32  registered PC of first word.

## Operation
- Register file: N_REGS×WIDTH, all zero on reset; written at clock edge when wb_we. Reads are combinational with write-through: a read of wb_addr while wb_we returns wb_data.
- FSM states RUN, IMM; reset → RUN.
- Priority per cycle: reset > flush > hold > load-use stall > normal.
- reset: all outputs and the latched first word clear to 0; state RUN; ex_is_load=0.
- flush: next cycle out_valid=0, ctrl_out=0, other outputs 0. Latched first word discarded; state RUN. Any word presented the same cycle is dropped; stall_out=0.
- hold: every output register, FSM state and latch keep their value; stall_out=1; register-file writes still occur.
- Load-use: hazard = ex_is_load & out_valid & ((uses_rs1 & rs1==rd_out) | (uses_rs2 & rs2==rd_out)), evaluated on the instruction about to issue. Hazard → bubble (out_valid=0, ctrl_out=0), stall_out=1, state unchanged.
- RUN, in_valid, two_word=0: issue. Outputs load ctrl_in, operands read at issue, rd_addr, pc; imm_out=0.
- RUN, in_valid, two_word=1: latch ctrl, qualifiers, addresses, pc; bubble issued; → IMM; stall_out=0.
- IMM, in_valid: issue latched instruction with imm_out = zero-extended instruction; operands read this cycle from the latched addresses; load-use check uses latched qualifiers; → RUN.
- IMM, !in_valid: wait; bubble.
- RUN, !in_valid: bubble.
- ex_is_load register is loaded with the issued instruction's is_load; cleared on bubble.

## Timing
- Latency: word accepted at edge N → outputs valid after edge N+1; two-word instructions issue one cycle after the immediate word is accepted.
- stall_out depends combinationally on hold, flush, the inputs and the ID/EX registers. It has no path from wb_*.
- Load-use costs exactly one bubble; the retry issues normally because ex_is_load is now 0.
- Reset mid-IMM aborts assembly; the first word is never issued.

## Structure
- Package decode_pkg: state enum {RUN, IMM}, packed struct for latched decode (ctrl, qualifiers, addresses, pc), default CTRL_W.
- Sub-module reg_file_bypass (WIDTH, N_REGS, two read ports, one write port, write-through).

## Test plan
- Reset, then wb_we to r3=0x1234 with same-cycle read of rs1=3 → rs1_data=0x1234 next cycle; all outputs 0 during reset.
- Load to r2 issued, next instruction uses rs2=2 → one bubble (out_valid=0), stall_out=1 one cycle, then issues with out_valid=1.
- two_word word 0x5A00 pc=0x20, then imm 0xBEEF → one bubble, then imm_out=0x(00..)BEEF, pc_out=0x20.
- flush while in IMM → next out_valid=0; following one-word instruction issues normally with imm_out=0.
- hold for 3 cycles with out_valid=1 → all outputs stable, stall_out=1; wb write during hold visible after release.
- N_REGS=16, WIDTH=32: write and read r15=0xDEADBEEF.
